multicycle_controller: RTL and testbench

- Next-generation RV32I control unit: a multicycle FSM replacing the single-cycle combinational main/ALU decoder pair.
- Sequences shared-memory fetch, decode, execute, memory and writeback over several cycles.
- Adds jalr, lui and auipc, a memory-ready handshake with optional timeout, and illegal-opcode detection.
- Sits beside the multicycle datapath and drives all of its mux selects and write enables.

---
 rtl/multicycle_controller_pkg.sv | 96 +++++++++
 rtl/multicycle_controller_alu_decoder.sv | 42 ++++
 rtl/multicycle_controller.sv | 239 +++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_controller_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_controller_pkg
// Shared definitions for the RV32I multicycle control unit: FSM state encoding,
// major opcodes, datapath select encodings, ALU operation classes and the
// immediate-format decode used by the controller.
// -----------------------------------------------------------------------------
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_JALR,
        S_LINK,
        S_BRANCH,
        S_UPPER,
        S_ILLEGAL,
        S_HALT
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        RES_ALUOUT    = 2'b00,
        RES_DATA      = 2'b01,
        RES_ALURESULT = 2'b10
    } result_src_e;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_RD1   = 2'b10,
        SRCA_ZERO  = 2'b11
    } src_a_e;

    typedef enum logic [1:0] {
        SRCB_RD2  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } src_b_e;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLT  = 4'b0101,
        ALU_SLTU = 4'b0110,
        ALU_SLL  = 4'b0111,
        ALU_SRL  = 4'b1000,
        ALU_SRA  = 4'b1001
    } alu_ctrl_e;

    // Operation class handed from the FSM to the ALU decoder.
    typedef enum logic [1:0] {
        ALUOP_ADD,
        ALUOP_SUB,
        ALUOP_RTYPE,
        ALUOP_ITYPE
    } alu_op_e;

    // Immediate format follows the opcode alone, independent of FSM state.
    function automatic imm_src_e imm_src_for(input logic [6:0] op);
        case (op)
            OP_STORE:         return IMM_S;
            OP_BRANCH:        return IMM_B;
            OP_JAL:           return IMM_J;
            OP_LUI, OP_AUIPC: return IMM_U;
            default:          return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// -----------------------------------------------------------------------------
// multicycle_controller_alu_decoder
// Maps the FSM's ALU operation class plus funct3/funct7b5 to ALUControl.
//   alu_op_i      in  2  operation class (fixed add, fixed sub, R-type, I-type)
//   funct3_i      in  3  instruction[14:12]
//   funct7b5_i    in  1  instruction[30]
//   alu_control_o out 4  ALU operation select
// -----------------------------------------------------------------------------
module multicycle_controller_alu_decoder
    import multicycle_controller_pkg::*;
(
    input  alu_op_e     alu_op_i,
    input  logic [2:0]  funct3_i,
    input  logic        funct7b5_i,
    output alu_ctrl_e   alu_control_o
);

    // NOTE: combinational blocks assign a default first so no path leaves the
    // output unassigned, which would otherwise infer a latch.
    always_comb begin
        alu_control_o = ALU_ADD;
        case (alu_op_i)
            ALUOP_ADD: alu_control_o = ALU_ADD;
            ALUOP_SUB: alu_control_o = ALU_SUB;
            default: begin
                case (funct3_i)
                    // bit 30 of an I-type add is immediate data, so only R-type subtracts
                    3'b000:  alu_control_o = (alu_op_i == ALUOP_RTYPE && funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_control_o = ALU_SLL;
                    3'b010:  alu_control_o = ALU_SLT;
                    3'b011:  alu_control_o = ALU_SLTU;
                    3'b100:  alu_control_o = ALU_XOR;
                    // srai and srli share funct3; bit 30 distinguishes them for both formats
                    3'b101:  alu_control_o = funct7b5_i ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_control_o = ALU_OR;
                    default: alu_control_o = ALU_AND;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
// RV32I multicycle control unit: sequences fetch, decode, execute, memory and
// writeback and drives the multicycle datapath's selects and write enables.
//
// Parameters:
//   USE_MEM_READY  1 = memory states wait for mem_ready, 0 = treated as ready
//   WAIT_TIMEOUT   0 = wait forever, N>0 = HALT after N consecutive stall cycles
// Build option:
//   BRANCH_FULL_EN defined   -> beq/bne/blt/bge/bltu/bgeu decoded
//   BRANCH_FULL_EN undefined -> only beq; other branch funct3 is illegal
//
// Ports:
//   clk, reset (async, active high)
//   op, funct3, funct7b5          instruction fields
//   Zero, Lt, Ltu                 ALU compare flags
//   mem_ready                     memory completes access this cycle
//   PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
//   RegWrite, ImmSrc, ALUControl  datapath controls
//   IllegalInstr                  one-cycle pulse on an undecodable instruction
//   Halted                        sticky, set on memory wait timeout
// -----------------------------------------------------------------------------
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter bit          USE_MEM_READY = 1'b1,
    parameter int unsigned WAIT_TIMEOUT  = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       Lt,
    input  logic       Ltu,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegWrite,
    output logic [2:0] ImmSrc,
    output logic [3:0] ALUControl,
    output logic       IllegalInstr,
    output logic       Halted
);

    localparam int CNT_W = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic ready;
    logic waiting;
    logic timeout;
    logic branch_ok;
    logic taken;

    assign ready   = USE_MEM_READY ? mem_ready : 1'b1;
    assign waiting = (state_q inside {S_FETCH, S_MEMREAD, S_MEMWRITE}) && !ready;
    // Fires on the stall cycle that would bring the count to WAIT_TIMEOUT;
    // a ready memory in that cycle clears waiting, so completion wins.
    assign timeout = (WAIT_TIMEOUT > 0) && waiting && ((32'(cnt_q) + 32'd1) == WAIT_TIMEOUT);

`ifdef BRANCH_FULL_EN
    assign branch_ok = !(funct3 inside {3'b010, 3'b011});
    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = Zero;
            3'b001:  taken = !Zero;
            3'b100:  taken = Lt;
            3'b101:  taken = !Lt;
            3'b110:  taken = Ltu;
            3'b111:  taken = !Ltu;
            default: taken = 1'b0;
        endcase
    end
`else
    logic unused_flags;
    assign unused_flags = Lt ^ Ltu;
    assign branch_ok    = (funct3 == 3'b000);
    assign taken        = Zero;
`endif

    // Next-state and wait-counter logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (ready)        state_d = S_DECODE;
                else if (timeout) state_d = S_HALT;
            end
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_JAL:            state_d = S_LINK;
                    OP_JALR:           state_d = S_JALR;
                    OP_BRANCH:         state_d = branch_ok ? S_BRANCH : S_ILLEGAL;
                    OP_LUI, OP_AUIPC:  state_d = S_UPPER;
                    default:           state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: begin
                if (ready)        state_d = S_MEMWB;
                else if (timeout) state_d = S_HALT;
            end
            S_MEMWRITE: begin
                if (ready)        state_d = S_FETCH;
                else if (timeout) state_d = S_HALT;
            end
            S_EXECR, S_EXECI, S_LINK, S_UPPER: state_d = S_ALUWB;
            S_JALR:     state_d = S_LINK;
            S_MEMWB, S_ALUWB, S_BRANCH, S_ILLEGAL: state_d = S_FETCH;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_FETCH;
        endcase

        if (state_d != state_q) cnt_d = '0;
        else if (waiting)       cnt_d = cnt_q + CNT_W'(1);
        else                    cnt_d = cnt_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Moore output decode from the registered state.
    logic        pc_write, ir_write, mem_write, reg_write, adr_src, illegal;
    result_src_e result_src;
    src_a_e      src_a;
    src_b_e      src_b;
    alu_op_e     alu_op;
    alu_ctrl_e   alu_control;

    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        adr_src    = 1'b0;
        illegal    = 1'b0;
        result_src = RES_ALUOUT;
        src_a      = SRCA_PC;
        src_b      = SRCB_RD2;
        alu_op     = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                src_b      = SRCB_FOUR;
                result_src = RES_ALURESULT;
                ir_write   = ready;
                pc_write   = ready;
            end
            S_DECODE: begin
                // Branch/jal target is precomputed into ALUOut here.
                src_a = SRCA_OLDPC;
                src_b = SRCB_IMM;
            end
            S_MEMADR, S_JALR: begin
                src_a = SRCA_RD1;
                src_b = SRCB_IMM;
            end
            S_MEMREAD:  adr_src = 1'b1;
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECR: begin
                src_a  = SRCA_RD1;
                alu_op = ALUOP_RTYPE;
            end
            S_EXECI: begin
                src_a  = SRCA_RD1;
                src_b  = SRCB_IMM;
                alu_op = ALUOP_ITYPE;
            end
            S_ALUWB:    reg_write = 1'b1;
            S_LINK: begin
                // PC takes the target held in ALUOut while OldPC+4 is formed.
                pc_write = 1'b1;
                src_a    = SRCA_OLDPC;
                src_b    = SRCB_FOUR;
            end
            S_BRANCH: begin
                src_a    = SRCA_RD1;
                alu_op   = ALUOP_SUB;
                pc_write = taken;
            end
            S_UPPER: begin
                src_a = (op == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
                src_b = SRCB_IMM;
            end
            S_ILLEGAL:  illegal = 1'b1;
            default: ;
        endcase
    end

    multicycle_controller_alu_decoder u_alu_decoder (
        .alu_op_i      (alu_op),
        .funct3_i      (funct3),
        .funct7b5_i    (funct7b5),
        .alu_control_o (alu_control)
    );

    // Enables are gated by reset so nothing writes while reset is asserted,
    // even though FETCH would otherwise follow mem_ready.
    assign PCWrite      = pc_write  & ~reset;
    assign IRWrite      = ir_write  & ~reset;
    assign MemWrite     = mem_write & ~reset;
    assign RegWrite     = reg_write & ~reset;
    assign AdrSrc       = adr_src;
    assign ResultSrc    = result_src;
    assign ALUSrcA      = src_a;
    assign ALUSrcB      = src_b;
    assign ImmSrc       = imm_src_for(op);
    assign ALUControl   = alu_control;
    assign IllegalInstr = illegal;
    assign Halted       = (state_q == S_HALT);

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
// Directed bench for multicycle_controller built with WAIT_TIMEOUT=4.
// The stimulus thread queues the hand-derived output vector for each cycle;
// a monitor pops and compares at the falling edge.
// Vector order: {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
//                ALUSrcB, RegWrite, ImmSrc, ALUControl, IllegalInstr, Halted}
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero, Lt, Ltu, mem_ready;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, IllegalInstr, Halted;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl;

    multicycle_controller #(.USE_MEM_READY(1'b1), .WAIT_TIMEOUT(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .op           (op),
        .funct3       (funct3),
        .funct7b5     (funct7b5),
        .Zero         (Zero),
        .Lt           (Lt),
        .Ltu          (Ltu),
        .mem_ready    (mem_ready),
        .PCWrite      (PCWrite),
        .AdrSrc       (AdrSrc),
        .MemWrite     (MemWrite),
        .IRWrite      (IRWrite),
        .ResultSrc    (ResultSrc),
        .ALUSrcA      (ALUSrcA),
        .ALUSrcB      (ALUSrcB),
        .RegWrite     (RegWrite),
        .ImmSrc       (ImmSrc),
        .ALUControl   (ALUControl),
        .IllegalInstr (IllegalInstr),
        .Halted       (Halted)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, RTYP = 7'b0110011,
                           ITYP = 7'b0010011, JAL   = 7'b1101111, JALR  = 7'b1100111,
                           BR   = 7'b1100011, LUI   = 7'b0110111, AUIPC = 7'b0010111;

    typedef struct {
        string       nm;
        logic [19:0] v;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    logic [19:0] act;
    assign act = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                  RegWrite, ImmSrc, ALUControl, IllegalInstr, Halted};

    task automatic check(input string nm, input logic [19:0] got, input logic [19:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%b want=%b", nm, got, want);
        end
    endtask

    function automatic logic [19:0] o(int pcw, int adr, int mw, int irw, int rs, int a, int b,
                                      int rw, int imm, int alu, int ill, int hlt);
        return {1'(pcw), 1'(adr), 1'(mw), 1'(irw), 2'(rs), 2'(a), 2'(b),
                1'(rw), 3'(imm), 4'(alu), 1'(ill), 1'(hlt)};
    endfunction

    // FETCH: PC+4 on ALUResult; IR/PC enables follow mem_ready.
    function automatic logic [19:0] f_fetch(int imm, int rdy);
        return o(rdy, 0, 0, rdy, 2, 0, 2, 0, imm, 0, 0, 0);
    endfunction

    // DECODE: OldPC + ImmExt.
    function automatic logic [19:0] f_dec(int imm);
        return o(0, 0, 0, 0, 0, 1, 1, 0, imm, 0, 0, 0);
    endfunction

    localparam logic [19:0] WB     = 20'b0000_00_00_00_1_000_0000_0_0;
    localparam logic [19:0] HALTED = 20'b0000_00_00_00_0_000_0000_0_1;

    task automatic push(input string nm, input logic [19:0] v);
        exp_t e;
        e.nm = nm;
        e.v  = v;
        exp_q.push_back(e);
    endtask

    // Describe the current cycle, then advance to just after the next rising edge.
    task automatic cyc(input string nm, input logic [19:0] v);
        push(nm, v);
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] o_, input logic [2:0] f3, input logic f7);
        op       = o_;
        funct3   = f3;
        funct7b5 = f7;
    endtask

    task automatic run_alu(input string nm, input logic [6:0] o_, input logic [2:0] f3,
                           input logic f7, input int alu);
        int b;
        b = (o_ == RTYP) ? 0 : 1;
        set_instr(o_, f3, f7);
        mem_ready = 1'b1;
        cyc({nm, ".fetch"},  f_fetch(0, 1));
        cyc({nm, ".decode"}, f_dec(0));
        cyc({nm, ".exec"},   o(0, 0, 0, 0, 0, 2, b, 0, 0, alu, 0, 0));
        cyc({nm, ".wb"},     WB);
    endtask

    // Monitor: compares one queued vector per falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check(mon_e.nm, act, mon_e.v);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        set_instr(RTYP, 3'b000, 1'b0);
        Zero = 1'b0; Lt = 1'b0; Ltu = 1'b0; mem_ready = 1'b1;
        @(posedge clk);
        #1;
        // Held in reset with mem_ready high: FETCH selects, all enables low.
        cyc("reset", o(0, 0, 0, 0, 2, 0, 2, 0, 0, 0, 0, 0));
        reset = 1'b0;

        // ALU instructions: R-type and I-type funct decode.
        run_alu("add",  RTYP, 3'b000, 1'b0, 0);
        run_alu("sub",  RTYP, 3'b000, 1'b1, 1);
        run_alu("sra",  RTYP, 3'b101, 1'b1, 9);
        run_alu("sltu", RTYP, 3'b011, 1'b0, 6);
        run_alu("addi", ITYP, 3'b000, 1'b1, 0);
        run_alu("srai", ITYP, 3'b101, 1'b1, 9);
        run_alu("srli", ITYP, 3'b101, 1'b0, 8);
        run_alu("andi", ITYP, 3'b111, 1'b0, 2);

        // lw with three stall cycles in MEMREAD.
        set_instr(LOAD, 3'b010, 1'b0);
        mem_ready = 1'b1;
        cyc("lw.fetch",  f_fetch(0, 1));
        cyc("lw.decode", f_dec(0));
        cyc("lw.memadr", o(0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0));
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc("lw.memread_stall", o(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        mem_ready = 1'b1;
        cyc("lw.memread_done", o(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc("lw.memwb",        o(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0));

        // sw with mem_ready delayed two cycles: MemWrite for three cycles.
        set_instr(STORE, 3'b010, 1'b0);
        cyc("sw.fetch",  f_fetch(1, 1));
        cyc("sw.decode", f_dec(1));
        cyc("sw.memadr", o(0, 0, 0, 0, 0, 2, 1, 0, 1, 0, 0, 0));
        mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) cyc("sw.memwrite_stall", o(0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        mem_ready = 1'b1;
        cyc("sw.memwrite_done", o(0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0));

        // beq taken after three FETCH stalls; ready on the would-be timeout cycle wins.
        set_instr(BR, 3'b000, 1'b0);
        Zero = 1'b1;
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc("beq.fetch_stall", f_fetch(2, 0));
        mem_ready = 1'b1;
        cyc("beq.fetch",  f_fetch(2, 1));
        cyc("beq.decode", f_dec(2));
        cyc("beq.taken",  o(1, 0, 0, 0, 0, 2, 0, 0, 2, 1, 0, 0));
        Zero = 1'b0;
        cyc("beqn.fetch",  f_fetch(2, 1));
        cyc("beqn.decode", f_dec(2));
        cyc("beqn.branch", o(0, 0, 0, 0, 0, 2, 0, 0, 2, 1, 0, 0));

        // bne with Zero=0 and bltu with Ltu=1.
        set_instr(BR, 3'b001, 1'b0);
        cyc("bne.fetch",  f_fetch(2, 1));
        cyc("bne.decode", f_dec(2));
`ifdef BRANCH_FULL_EN
        cyc("bne.taken",  o(1, 0, 0, 0, 0, 2, 0, 0, 2, 1, 0, 0));
`else
        cyc("bne.illegal", o(0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1, 0));
`endif
        set_instr(BR, 3'b110, 1'b0);
        Ltu = 1'b1;
        cyc("bltu.fetch",  f_fetch(2, 1));
        cyc("bltu.decode", f_dec(2));
`ifdef BRANCH_FULL_EN
        cyc("bltu.taken",  o(1, 0, 0, 0, 0, 2, 0, 0, 2, 1, 0, 0));
`else
        cyc("bltu.illegal", o(0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1, 0));
`endif
        Ltu = 1'b0;

        // jalr: JALR -> LINK -> ALUWB.
        set_instr(JALR, 3'b000, 1'b0);
        cyc("jalr.fetch",  f_fetch(0, 1));
        cyc("jalr.decode", f_dec(0));
        cyc("jalr.jalr",   o(0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0));
        cyc("jalr.link",   o(1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0));
        cyc("jalr.wb",     WB);

        // jal goes straight from DECODE to LINK.
        set_instr(JAL, 3'b000, 1'b0);
        cyc("jal.fetch",  f_fetch(3, 1));
        cyc("jal.decode", f_dec(3));
        cyc("jal.link",   o(1, 0, 0, 0, 0, 1, 2, 0, 3, 0, 0, 0));
        cyc("jal.wb",     o(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0));

        // lui / auipc.
        set_instr(LUI, 3'b000, 1'b0);
        cyc("lui.fetch",  f_fetch(4, 1));
        cyc("lui.decode", f_dec(4));
        cyc("lui.upper",  o(0, 0, 0, 0, 0, 3, 1, 0, 4, 0, 0, 0));
        cyc("lui.wb",     o(0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0));
        set_instr(AUIPC, 3'b000, 1'b0);
        cyc("auipc.fetch",  f_fetch(4, 1));
        cyc("auipc.decode", f_dec(4));
        cyc("auipc.upper",  o(0, 0, 0, 0, 0, 1, 1, 0, 4, 0, 0, 0));
        cyc("auipc.wb",     o(0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0));

        // Illegal opcode pulses once, then back to FETCH.
        set_instr(7'b0000000, 3'b000, 1'b0);
        cyc("ill.fetch",   f_fetch(0, 1));
        cyc("ill.decode",  f_dec(0));
        cyc("ill.pulse",   o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        cyc("ill.refetch", f_fetch(0, 1));
        cyc("ill.decode2", f_dec(0));
        cyc("ill.pulse2",  o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));

        // Reset in the middle of a stalled store drops MemWrite at once.
        set_instr(STORE, 3'b010, 1'b0);
        cyc("swr.fetch",  f_fetch(1, 1));
        cyc("swr.decode", f_dec(1));
        cyc("swr.memadr", o(0, 0, 0, 0, 0, 2, 1, 0, 1, 0, 0, 0));
        mem_ready = 1'b0;
        push("swr.memwrite", o(0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("swr.async_memwrite", 20'(MemWrite), 20'd0);
        check("swr.async_adrsrc",   20'(AdrSrc),   20'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Four FETCH stalls reach the timeout; HALT is sticky even with mem_ready.
        set_instr(RTYP, 3'b000, 1'b0);
        for (int i = 0; i < 4; i++) cyc("to.fetch_stall", f_fetch(0, 0));
        cyc("to.halt", HALTED);
        mem_ready = 1'b1;
        cyc("to.halt_sticky", HALTED);
        push("to.halt_last", HALTED);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("to.async_halted", 20'(Halted),  20'd0);
        check("to.async_irwrite", 20'(IRWrite), 20'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc("to.after_reset_fetch",  f_fetch(0, 1));
        cyc("to.after_reset_decode", f_dec(0));

        check("queue_drained", 20'(exp_q.size()), 20'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
